channel_link_arbiter: RTL

Shares one channel's TX/RX FIFO pair between two transfer managers in the MFPGA: the register transfer manager (RTM, IPbus command/response traffic) and the data transfer manager (DTM, bulk readout). Grants the channel to one manager at a time with round-robin fairness, drives that manager's `run_*` start strobe, and tracks its `*_done` level to release the channel. Muxes the granted manager's streams onto the channel FIFOs. Aborts grants whose manager never starts.

---
 rtl/channel_link_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/channel_link_arbiter.sv
// Round-robin owner of one channel's TX/RX FIFO pair, shared by the register (RTM)
// and data (DTM) transfer managers. Grants, start strobes, release and start-timeout abort.
module channel_link_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rtm_req,
  input  logic        dtm_req,
  input  logic        rtm_done,
  input  logic        dtm_done,
  output logic        run_rtm,
  output logic        run_dtm,
  input  logic [31:0] rtm_tx_data,
  input  logic [3:0]  rtm_tx_dest,
  input  logic        rtm_tx_last,
  input  logic        rtm_tx_valid,
  output logic        rtm_tx_ready,
  input  logic [31:0] dtm_tx_data,
  input  logic [3:0]  dtm_tx_dest,
  input  logic        dtm_tx_last,
  input  logic        dtm_tx_valid,
  output logic        dtm_tx_ready,
  output logic [31:0] chan_tx_fifo_data,
  output logic [3:0]  chan_tx_fifo_dest,
  output logic        chan_tx_fifo_last,
  output logic        chan_tx_fifo_valid,
  input  logic        chan_tx_fifo_ready,
  input  logic [31:0] chan_rx_fifo_data,
  input  logic        chan_rx_fifo_last,
  input  logic        chan_rx_fifo_valid,
  output logic        chan_rx_fifo_ready,
  output logic [31:0] rtm_rx_data,
  output logic        rtm_rx_last,
  output logic        rtm_rx_valid,
  input  logic        rtm_rx_ready,
  output logic [31:0] dtm_rx_data,
  output logic        dtm_rx_last,
  output logic        dtm_rx_valid,
  input  logic        dtm_rx_ready,
  output logic [1:0]  grant,
  output logic [7:0]  abort_count
);

  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, START_RTM, BUSY_RTM, START_DTM, BUSY_DTM, RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    abort_q, abort_d;
  logic          last_dtm_q, last_dtm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      abort_q    <= '0;
      last_dtm_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      last_dtm_q <= last_dtm_d;
    end
  end

  // The start counter only runs inside START_x and is cleared everywhere else.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    abort_d    = abort_q;
    last_dtm_d = last_dtm_q;
    case (state_q)
      IDLE: begin
        if (rtm_req && (!dtm_req || last_dtm_q)) state_d = START_RTM;
        else if (dtm_req)                         state_d = START_DTM;
      end
      START_RTM: begin
        if (!rtm_done) begin
          state_d = BUSY_RTM;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          state_d    = IDLE;
          abort_d    = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
          last_dtm_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY_RTM: begin
        if (rtm_done) begin
          state_d    = RELEASE;
          last_dtm_d = 1'b0;
        end
      end
      START_DTM: begin
        if (!dtm_done) begin
          state_d = BUSY_DTM;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          state_d    = IDLE;
          abort_d    = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
          last_dtm_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY_DTM: begin
        if (dtm_done) begin
          state_d    = RELEASE;
          last_dtm_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run_rtm     = (state_q == START_RTM);
  assign run_dtm     = (state_q == START_DTM);
  assign abort_count = abort_q;

  always_comb begin
    grant = 2'b00;
    if (state_q == START_RTM || state_q == BUSY_RTM) grant = 2'b01;
    if (state_q == START_DTM || state_q == BUSY_DTM) grant = 2'b10;
  end

  assign rtm_rx_data = chan_rx_fifo_data;
  assign rtm_rx_last = chan_rx_fifo_last;
  assign dtm_rx_data = chan_rx_fifo_data;
  assign dtm_rx_last = chan_rx_fifo_last;

  // Stream mux follows the state-decoded grant only, so it never switches mid-transfer.
  always_comb begin
    chan_tx_fifo_data  = '0;
    chan_tx_fifo_dest  = '0;
    chan_tx_fifo_last  = 1'b0;
    chan_tx_fifo_valid = 1'b0;
    chan_rx_fifo_ready = 1'b0;
    rtm_tx_ready       = 1'b0;
    dtm_tx_ready       = 1'b0;
    rtm_rx_valid       = 1'b0;
    dtm_rx_valid       = 1'b0;
    case (grant)
      2'b01: begin
        chan_tx_fifo_data  = rtm_tx_data;
        chan_tx_fifo_dest  = rtm_tx_dest;
        chan_tx_fifo_last  = rtm_tx_last;
        chan_tx_fifo_valid = rtm_tx_valid;
        rtm_tx_ready       = chan_tx_fifo_ready;
        rtm_rx_valid       = chan_rx_fifo_valid;
        chan_rx_fifo_ready = rtm_rx_ready;
      end
      2'b10: begin
        chan_tx_fifo_data  = dtm_tx_data;
        chan_tx_fifo_dest  = dtm_tx_dest;
        chan_tx_fifo_last  = dtm_tx_last;
        chan_tx_fifo_valid = dtm_tx_valid;
        dtm_tx_ready       = chan_tx_fifo_ready;
        dtm_rx_valid       = chan_rx_fifo_valid;
        chan_rx_fifo_ready = dtm_rx_ready;
      end
      default: ;
    endcase
  end

endmodule
